point_alu_sched: RTL and testbench
==================================

# point_alu_sched

Round-robin scheduler that shares one `point_alu` instance (double/add/reduce on 765-bit projective points) between `NREQ` independent requesters, such as parallel scalar-multiply sequencers. Each requester issues one operation with a valid/ready handshake. The scheduler drives the ALU's single-pulse `ivalid` protocol, keeps at most one operation in flight, and returns the result to the owning requester over a valid/ready response channel. It sits between the scalar-multiply controllers and `point_alu` inside `ed25519`.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters (2..8).
- `PW`, default 765: point width, {X,Y,Z} × 255 bits.
- `TMO`, default 4095: ALU watchdog limit in cycles. Used only with `PT_SCHED_TMO_EN`.

Ports:
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_req_valid`, in, NREQ: per-requester operation request.
- `o_req_ready`, out, NREQ: one-hot grant/accept.
- `i_req_op`, in, 2×NREQ: op per requester. 00 = double, 01 = add, 11 = reduce.
- `i_req_p1`, in, PW×NREQ: operand 1 per requester.
- `i_req_p2`, in, PW×NREQ: operand 2 per requester.
- `o_rsp_valid`, out, NREQ: one-hot result valid to the owner.
- `i_rsp_ready`, in, NREQ: per-requester result accept.
- `o_rsp_point`, out, PW: result point, shared by all requesters.
- `o_rsp_err`, out, 1: result produced by watchdog expiry.
- `o_alu_ivalid`, out, 1: one-cycle start pulse to the ALU.
- `o_alu_op`, out, 2: registered op.
- `o_alu_point1`, out, PW: registered operand 1.
- `o_alu_point2`, out, PW: registered operand 2.
- `i_alu_ovalid`, in, 1: ALU result pulse.
- `i_alu_opoint`, in, PW: ALU result.
- `o_busy`, out, 1: state ≠ IDLE.

## Operation
- FSM states:
  - IDLE: if any valid, take the arbiter grant; go to ISSUE.
  - ISSUE: go to WAIT unconditionally.
  - WAIT: on `i_alu_ovalid` go to RESP.
  - RESP: when the owner's `i_rsp_ready` is high, go to IDLE.
- Grant:
  - `o_req_ready[g]` is combinational, high only in IDLE, for exactly one `g` with `i_req_valid[g]` = 1.
  - Accept fires when valid and ready are both high. On accept, latch op, p1, p2 and owner index.
- Arbitration:
  - Round-robin. Search starts at pointer `ptr`, wraps at NREQ−1 → 0, and takes the lowest valid index at or after `ptr`.
  - On grant, `ptr` becomes g+1 mod NREQ.
  - Reset value of `ptr` is 0.
- Ops are passed through unchanged. Op code 10 is forwarded as-is; `point_alu` defines its behaviour.
- ALU outputs:
  - `o_alu_ivalid` = (state == ISSUE). It is high for exactly one cycle per accepted request.
  - Operands hold stable from ISSUE until the next accept.
- Result capture:
  - `i_alu_ovalid` is sampled only in WAIT. On capture, `i_alu_opoint` is latched into the result register, `o_rsp_err` = 0.
  - `i_alu_ovalid` in any other state is ignored, including a stale result after reset.
- RESP: `o_rsp_valid[owner]` = 1 and all other bits 0. `o_rsp_point` and `o_rsp_err` are stable until accepted.
- Requesters that are not granted may drop or change their request freely. A granted request is already latched.
- Reset mid-operation: state goes to IDLE, ptr to 0, all valids and `o_alu_ivalid` low. An in-flight ALU op is abandoned.
- Reset values: `o_req_ready` 0 while `i_rst` is asserted, `o_rsp_valid` 0, `o_rsp_point` 0, `o_rsp_err` 0, `o_alu_ivalid` 0, `o_alu_op` 0, ALU points 0, `o_busy` 0.

## Timing
- Accept at the edge ending cycle 0; ISSUE in cycle 1 with `o_alu_ivalid` = 1; WAIT from cycle 2.
- `i_alu_ovalid` in cycle k gives `o_rsp_valid` in cycle k+1.
- Response accepted in cycle m gives IDLE in cycle m+1, where the next grant can occur.
- Minimum overhead is 3 cycles beyond ALU latency, plus response stall cycles.
- `o_alu_ivalid` is never asserted while WAIT or RESP is pending. This guarantees a single outstanding op.

## Configuration
- Macro: `PT_SCHED_TMO_EN`.
- Defined:
  - A 16-bit counter clears on ISSUE and increments in WAIT.
  - If it reaches `TMO` without `i_alu_ovalid`, go to RESP with `o_rsp_point` = 0 and `o_rsp_err` = 1.
  - A same-cycle `i_alu_ovalid` wins over expiry.
  - A late `i_alu_ovalid` after expiry is ignored.
- Undefined: no counter exists, WAIT is unbounded, and `o_rsp_err` is tied to 0.

## Structure
- Package `ed25519_pkg`:
  - `PW`, `OP_DOUBLE` = 2'b00, `OP_ADD` = 2'b01, `OP_REDUCE` = 2'b11.
  - Scheduler state enum `sched_state_e` {IDLE, ISSUE, WAIT, RESP}.
- Sub-module `rr_arbiter`: parameter NREQ; inputs req and ptr; outputs one-hot grant and binary index. It is purely combinational. The pointer register lives in `point_alu_sched`.

## Test plan
- Single request: req0 op=01, p1=A, p2=B; ALU model latency 20. Expect `o_alu_ivalid` in cycle 1 with A/B driven, `o_rsp_valid` = 01 in cycle 22, `o_rsp_point` = model result.
- Contention: req0 and req1 held continuously, 4 ops each. Expect grant order 0,1,0,1,… and exactly one `o_alu_ivalid` per response.
- Response stall: hold `i_rsp_ready` = 0 for 10 cycles in RESP. Expect the point stable, no new grant, and `o_alu_ivalid` low throughout.
- Stray ALU pulse: `i_alu_ovalid` in IDLE and in RESP. Expect no state change and the result register unchanged.
- Reset in WAIT, then the ALU returns a result 5 cycles later. Expect IDLE, all outputs 0, stale result ignored, and the next request served normally with ptr = 0.
- With `PT_SCHED_TMO_EN` and TMO=50, the ALU never responds. Expect `o_rsp_valid` 51 cycles after ISSUE with point 0 and `o_rsp_err` = 1.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared constants and types for the ed25519 point datapath and its ALU scheduler.
package ed25519_pkg;
    localparam int PW = 765;

    localparam logic [1:0] OP_DOUBLE = 2'b00;
    localparam logic [1:0] OP_ADD    = 2'b01;
    localparam logic [1:0] OP_REDUCE = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} sched_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx
);
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end
endmodule

// File: rtl/point_alu_sched.sv
// Shares one point_alu among NREQ requesters, one op in flight at a time.
// Optional ALU watchdog: define PT_SCHED_TMO_EN.
module point_alu_sched
    import ed25519_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = ed25519_pkg::PW,
    parameter int TMO  = 4095
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [NREQ-1:0]          i_req_valid,
    output logic [NREQ-1:0]          o_req_ready,
    input  logic [NREQ-1:0][1:0]     i_req_op,
    input  logic [NREQ-1:0][PW-1:0]  i_req_p1,
    input  logic [NREQ-1:0][PW-1:0]  i_req_p2,
    output logic [NREQ-1:0]          o_rsp_valid,
    input  logic [NREQ-1:0]          i_rsp_ready,
    output logic [PW-1:0]            o_rsp_point,
    output logic                     o_rsp_err,
    output logic                     o_alu_ivalid,
    output logic [1:0]               o_alu_op,
    output logic [PW-1:0]            o_alu_point1,
    output logic [PW-1:0]            o_alu_point2,
    input  logic                     i_alu_ovalid,
    input  logic [PW-1:0]            i_alu_opoint,
    output logic                     o_busy
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
        $error("point_alu_sched: NREQ must be 2..8");
    end
    if (TMO < 1 || TMO > 65535) begin : g_bad_tmo
        $error("point_alu_sched: TMO must fit the 16-bit watchdog");
    end

    sched_state_e   state, state_d;
    logic [IW-1:0]  ptr, owner, gnt_idx;
    logic [NREQ-1:0] gnt;
    logic [1:0]     op_q;
    logic [PW-1:0]  p1_q, p2_q, rsp_q;
    logic           accept;

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req (i_req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gnt_idx)
    );

`ifdef PT_SCHED_TMO_EN
    logic [15:0] tmo_cnt;
    logic        err_q;
    logic        tmo_hit;
    // Expires on the TMO-th WAIT cycle; a same-cycle ALU result takes priority.
    assign tmo_hit   = (state == WAIT) && !i_alu_ovalid && (tmo_cnt == 16'(TMO - 1));
    assign o_rsp_err = err_q;
`else
    assign o_rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        case (state)
            IDLE:  if (|gnt) begin
                       accept  = 1'b1;
                       state_d = ISSUE;
                   end
            ISSUE: state_d = WAIT;
            WAIT:  begin
                if (i_alu_ovalid) state_d = RESP;
`ifdef PT_SCHED_TMO_EN
                else if (tmo_hit) state_d = RESP;
`endif
            end
            RESP:  if (i_rsp_ready[owner]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= IDLE;
        else       state <= state_d;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr   <= '0;
            owner <= '0;
            op_q  <= '0;
            p1_q  <= '0;
            p2_q  <= '0;
            rsp_q <= '0;
`ifdef PT_SCHED_TMO_EN
            err_q   <= 1'b0;
            tmo_cnt <= '0;
`endif
        end else begin
            if (accept) begin
                owner <= gnt_idx;
                op_q  <= i_req_op[gnt_idx];
                p1_q  <= i_req_p1[gnt_idx];
                p2_q  <= i_req_p2[gnt_idx];
                ptr   <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end
            // Result pulses outside WAIT (stale or stray) never touch the register.
            if (state == WAIT && i_alu_ovalid) begin
                rsp_q <= i_alu_opoint;
`ifdef PT_SCHED_TMO_EN
                err_q <= 1'b0;
            end else if (tmo_hit) begin
                rsp_q <= '0;
                err_q <= 1'b1;
`endif
            end
`ifdef PT_SCHED_TMO_EN
            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 16'd1;
`endif
        end
    end

    always_comb begin
        o_rsp_valid = '0;
        if (state == RESP) o_rsp_valid[owner] = 1'b1;
    end

    assign o_req_ready  = (state == IDLE && !i_rst) ? gnt : '0;
    assign o_rsp_point  = rsp_q;
    assign o_alu_ivalid = (state == ISSUE);
    assign o_alu_op     = op_q;
    assign o_alu_point1 = p1_q;
    assign o_alu_point2 = p2_q;
    assign o_busy       = (state != IDLE);
endmodule

// File: tb/tb_point_alu_sched.sv
// Randomized + directed bench for point_alu_sched against a transaction-level model.
module tb_point_alu_sched;
    localparam int N   = 2;
    localparam int PW  = 765;
    localparam int TMO = 50;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic [N-1:0]          i_req_valid = '0;
    logic [N-1:0]          o_req_ready;
    logic [N-1:0][1:0]     i_req_op = '0;
    logic [N-1:0][PW-1:0]  i_req_p1 = '0;
    logic [N-1:0][PW-1:0]  i_req_p2 = '0;
    logic [N-1:0]          o_rsp_valid;
    logic [N-1:0]          i_rsp_ready = '0;
    logic [PW-1:0]         o_rsp_point;
    logic                  o_rsp_err;
    logic                  o_alu_ivalid;
    logic [1:0]            o_alu_op;
    logic [PW-1:0]         o_alu_point1, o_alu_point2;
    logic                  i_alu_ovalid = 1'b0;
    logic [PW-1:0]         i_alu_opoint = '0;
    logic                  o_busy;

    point_alu_sched #(.NREQ(N), .PW(PW), .TMO(TMO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
        .i_req_p1(i_req_p1), .i_req_p2(i_req_p2),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_point(o_rsp_point), .o_rsp_err(o_rsp_err),
        .o_alu_ivalid(o_alu_ivalid), .o_alu_op(o_alu_op),
        .o_alu_point1(o_alu_point1), .o_alu_point2(o_alu_point2),
        .i_alu_ovalid(i_alu_ovalid), .i_alu_opoint(i_alu_opoint), .o_busy(o_busy)
    );

    initial forever #5 i_clk = ~i_clk;

    int checks = 0, fails = 0, cyc = 0;
    bit chk_en = 0;

    task automatic chk_v(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_p(string nm, logic [PW-1:0] act, logic [PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rnd_pt();
        logic [PW-1:0] r = '0;
        for (int i = 0; i < 24; i++) r = (r << 32) | PW'($urandom);
        return r;
    endfunction

    // Stand-in ALU function; any deterministic mix of op and operands will do.
    function automatic logic [PW-1:0] alu_f(logic [1:0] op, logic [PW-1:0] a, logic [PW-1:0] b);
        return (a ^ {b[PW-2:0], b[PW-1]}) + PW'(op);
    endfunction

    function automatic int rr_pick(logic [N-1:0] v, int p);
        for (int i = 0; i < N; i++)
            if (v[(p + i) % N]) return (p + i) % N;
        return -1;
    endfunction

    // ALU responder state (stimulus side)
    bit            alu_en = 1;
    int            alu_lat = 20;
    int            alu_due = -1;
    logic [PW-1:0] alu_res = '0;
    bit            stray = 0;

    // Transaction-level model
    bit            m_idle = 1, m_pend = 0, m_err = 0;
    int            m_ptr = 0, m_owner = 0, m_issue = -100;
    logic [1:0]    m_op = '0;
    logic [PW-1:0] m_p1 = '0, m_p2 = '0, m_pt = '0;
    logic [N-1:0]  exp_ready, exp_rv;
    int            g;

    // Recorders for directed checks
    int            t_iv = -1, t_rv = -1, cnt_iv = 0, cnt_rsp = 0;
    logic [PW-1:0] iv_p1, iv_p2, rv_pt;
    logic [N-1:0]  rv_vec;
    logic          rv_err;
    int            gq[$];

    always @(negedge i_clk) begin
        if (chk_en) begin
            exp_ready = '0;
            g = -1;
            if (m_idle && !i_rst) begin
                g = rr_pick(i_req_valid, m_ptr);
                if (g >= 0) exp_ready[g] = 1'b1;
            end
            exp_rv = '0;
            if (m_pend) exp_rv[m_owner] = 1'b1;
            chk_v("req_ready", o_req_ready, exp_ready);
            chk_v("alu_ivalid", o_alu_ivalid, cyc == m_issue);
            chk_v("alu_op", o_alu_op, m_op);
            chk_p("alu_p1", o_alu_point1, m_p1);
            chk_p("alu_p2", o_alu_point2, m_p2);
            chk_v("rsp_valid", o_rsp_valid, exp_rv);
            chk_p("rsp_point", o_rsp_point, m_pt);
            chk_v("rsp_err", o_rsp_err, m_err);
            chk_v("busy", o_busy, !m_idle);

            if (o_alu_ivalid === 1'b1) begin
                cnt_iv++;
                if (t_iv < 0) begin t_iv = cyc; iv_p1 = o_alu_point1; iv_p2 = o_alu_point2; end
            end
            if (|o_rsp_valid && t_rv < 0) begin
                t_rv = cyc; rv_pt = o_rsp_point; rv_err = o_rsp_err; rv_vec = o_rsp_valid;
            end
            if (|(o_rsp_valid & i_rsp_ready)) cnt_rsp++;
            if (|(o_req_ready & i_req_valid)) gq.push_back(o_req_ready[1] ? 1 : 0);

            // Advance the model across the coming edge
            if (i_rst) begin
                m_idle = 1; m_pend = 0; m_err = 0; m_ptr = 0; m_owner = 0; m_issue = -100;
                m_op = '0; m_p1 = '0; m_p2 = '0; m_pt = '0;
            end else if (m_idle) begin
                if (g >= 0) begin
                    m_owner = g; m_op = i_req_op[g]; m_p1 = i_req_p1[g]; m_p2 = i_req_p2[g];
                    m_ptr = (g + 1) % N; m_idle = 0; m_issue = cyc + 1;
                end
            end else if (m_pend) begin
                if (i_rsp_ready[m_owner]) begin m_idle = 1; m_pend = 0; end
            end else if (cyc > m_issue) begin
                if (i_alu_ovalid) begin m_pend = 1; m_pt = i_alu_opoint; m_err = 0; end
`ifdef PT_SCHED_TMO_EN
                else if (cyc - m_issue == TMO) begin m_pend = 1; m_pt = '0; m_err = 1; end
`endif
            end
        end
        if (alu_en && o_alu_ivalid === 1'b1) begin
            alu_due = cyc + alu_lat;
            alu_res = alu_f(o_alu_op, o_alu_point1, o_alu_point2);
        end
    end

    task automatic step();
        @(posedge i_clk);
        cyc++;
        #1;
        i_alu_ovalid = (cyc == alu_due) || stray;
        i_alu_opoint = (cyc == alu_due) ? alu_res : rnd_pt();
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    int t0, civ, cr, gs;
    logic [PW-1:0] snap;

    initial begin
        repeat (3) step();
        chk_en = 1;
        step();
        i_rst = 0;
        repeat (2) step();

        // Single request, latency 20
        t_iv = -1; t_rv = -1; alu_lat = 20;
        i_req_valid = 2'b01; i_req_op[0] = 2'b01;
        i_req_p1[0] = 765'h10; i_req_p2[0] = 765'h3; i_rsp_ready = 2'b11;
        t0 = cyc;
        step(); i_req_valid = '0;
        for (int k = 0; k < 60 && t_rv < 0; k++) step();
        chk_v("t1_iv_cycle", t_iv, t0 + 1);
        chk_p("t1_iv_p1", iv_p1, 765'h10);
        chk_p("t1_iv_p2", iv_p2, 765'h3);
        chk_v("t1_rv_cycle", t_rv, t0 + 22);
        chk_v("t1_rv_vec", rv_vec, 2'b01);
        chk_p("t1_rv_point", rv_pt, 765'h17);

        // Contention: both held; ptr is 1 after the single request
        alu_lat = 4; gs = gq.size(); civ = cnt_iv; cr = cnt_rsp;
        i_req_valid = 2'b11;
        i_req_op[0] = 2'b00; i_req_op[1] = 2'b11;
        i_req_p1[0] = rnd_pt(); i_req_p1[1] = rnd_pt();
        for (int k = 0; k < 300 && gq.size() < gs + 8; k++) step();
        i_req_valid = '0;
        for (int k = 0; k < 60 && cnt_rsp < cr + 8; k++) step();
        chk_v("t2_grants", gq.size() - gs, 8);
        for (int i = 0; i < 8 && gs + i < gq.size(); i++)
            chk_v("t2_order", gq[gs + i], (i % 2 == 0) ? 1 : 0);
        chk_v("t2_ivalids", cnt_iv - civ, 8);
        chk_v("t2_rsps", cnt_rsp - cr, 8);

        // Response stall with a competing request and a stray ALU pulse in RESP
        t_rv = -1; alu_lat = 3; i_rsp_ready = '0;
        i_req_valid = 2'b01; i_req_p1[0] = rnd_pt(); i_req_p2[0] = rnd_pt();
        step(); i_req_valid = 2'b10;
        for (int k = 0; k < 30 && t_rv < 0; k++) step();
        chk_v("t3_rv_seen", t_rv >= 0, 1);
        snap = rv_pt; civ = cnt_iv;
        for (int k = 0; k < 10; k++) begin
            stray = (k == 3);
            step();
            stray = 0;
            @(negedge i_clk);
            chk_p("t3_stall_point", o_rsp_point, snap);
            chk_v("t3_stall_ready", o_req_ready, 2'b00);
            chk_v("t3_stall_valid", o_rsp_valid, 2'b01);
        end
        chk_v("t3_no_issue", cnt_iv - civ, 0);
        i_rsp_ready = 2'b11; gs = gq.size();
        for (int k = 0; k < 20 && gq.size() <= gs; k++) step();
        i_req_valid = '0;
        for (int k = 0; k < 40 && o_busy; k++) step();
        // Stray pulse in IDLE
        snap = o_rsp_point;
        stray = 1; step(); stray = 0; step();
        @(negedge i_clk);
        chk_p("t4_idle_stray_point", o_rsp_point, snap);
        chk_v("t4_idle_stray_busy", o_busy, 0);

        // Reset in WAIT; stale ALU result arrives 5 cycles later
        t_iv = -1; alu_lat = 8;
        i_req_valid = 2'b01;
        step(); i_req_valid = '0;
        for (int k = 0; k < 10 && t_iv < 0; k++) step();
        step(); i_rst = 1;
        step(); i_rst = 0;
        @(negedge i_clk);
        chk_v("t5_busy_after_rst", o_busy, 0);
        chk_p("t5_point_after_rst", o_rsp_point, '0);
        for (int k = 0; k < 8; k++) step();
        @(negedge i_clk);
        chk_v("t5_stale_ignored", o_rsp_valid, 2'b00);
        step(); i_req_valid = 2'b11; cr = cnt_rsp;
        @(negedge i_clk);
        chk_v("t5_ptr_zero", o_req_ready, 2'b01);
        step(); i_req_valid = '0;
        for (int k = 0; k < 30 && cnt_rsp == cr; k++) step();
        chk_v("t5_served", cnt_rsp - cr, 1);

`ifdef PT_SCHED_TMO_EN
        // Watchdog: ALU never answers
        alu_en = 0; t_iv = -1; t_rv = -1;
        i_req_valid = 2'b10;
        step(); i_req_valid = '0;
        for (int k = 0; k < 120 && t_rv < 0; k++) step();
        chk_v("t6_tmo_delay", t_rv - t_iv, 51);
        chk_v("t6_tmo_err", rv_err, 1);
        chk_p("t6_tmo_point", rv_pt, '0);
        alu_en = 1;
        repeat (3) step();
`endif

        // Randomized traffic
        for (int k = 0; k < 1500; k++) begin
            step();
            alu_lat = $urandom_range(1, 6);
            i_req_valid = N'($urandom);
            i_rsp_ready = N'($urandom) | N'(($urandom % 3 == 0) ? 0 : 3);
            for (int r = 0; r < N; r++) begin
                i_req_op[r] = 2'($urandom);
                if ($urandom % 4 == 0) begin i_req_p1[r] = rnd_pt(); i_req_p2[r] = rnd_pt(); end
            end
            stray = ($urandom % 25 == 0);
        end
        stray = 0; i_req_valid = '0; i_rsp_ready = 2'b11;
        repeat (40) step();
        @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
